// File: rtl/dual_ram_scheduler.sv
// Front-end controller for a 1-write/2-read RAM: round-robin write arbitration over NR clients,
// fixed-latency read sequencing on two ports, and same-cycle write-to-read forwarding.
module dual_ram_scheduler #(
  parameter int BW = 32,
  parameter int AW = 5,
  parameter int NR = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NR-1:0]    wr_req,
  input  logic [NR*AW-1:0] wr_addr,
  input  logic [NR*BW-1:0] wr_data,
  output logic [NR-1:0]    wr_gnt,
  input  logic             rd_req1,
  input  logic [AW-1:0]    rd_addr1,
  output logic             rd_vld1,
  output logic [BW-1:0]    rd_data1,
  input  logic             rd_req2,
  input  logic [AW-1:0]    rd_addr2,
  output logic             rd_vld2,
  output logic [BW-1:0]    rd_data2,
  output logic             ram_write_en,
  output logic [AW-1:0]    ram_addr_in,
  output logic [BW-1:0]    ram_data_in,
  output logic             ram_read_en1,
  output logic [AW-1:0]    ram_addr_out_1,
  input  logic [BW-1:0]    ram_data_out1,
  output logic             ram_read_en2,
  output logic [AW-1:0]    ram_addr_out_2,
  input  logic [BW-1:0]    ram_data_out2
);

  localparam int PW = (NR > 1) ? $clog2(NR) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gnt_idx;
  logic [PW:0]   cand;
  logic          gnt_found;
  logic [NR-1:0] gnt;
  logic [AW-1:0] sel_addr;
  logic [BW-1:0] sel_data;

  logic          byp1;
  logic          byp2;
  logic [BW-1:0] byp_data;
  logic [BW-1:0] rd_hold1;
  logic [BW-1:0] rd_hold2;

  // Rotating search: first requester at or above rr_ptr, wrapping modulo NR
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NR)) begin
        cand = cand - (PW+1)'(NR);
      end
      if (!gnt_found && wr_req[cand[PW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    gnt      = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (gnt_found && gnt_idx == PW'(i)) begin
        gnt[i]   = 1'b1;
        sel_addr = wr_addr[i*AW +: AW];
        sel_data = wr_data[i*BW +: BW];
      end
    end
  end

  assign wr_gnt = rst_n ? gnt : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (gnt_found) begin
      rr_ptr <= (gnt_idx == PW'(NR-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_write_en <= 1'b0;
      ram_addr_in  <= '0;
      ram_data_in  <= '0;
    end else begin
      ram_write_en <= gnt_found;
      if (gnt_found) begin
        ram_addr_in <= sel_addr;
        ram_data_in <= sel_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_read_en1   <= 1'b0;
      ram_addr_out_1 <= '0;
      ram_read_en2   <= 1'b0;
      ram_addr_out_2 <= '0;
    end else begin
      ram_read_en1 <= rd_req1;
      ram_read_en2 <= rd_req2;
      if (rd_req1) ram_addr_out_1 <= rd_addr1;
      if (rd_req2) ram_addr_out_2 <= rd_addr2;
    end
  end

  // The RAM returns pre-write contents on a same-cycle collision, so the write data is
  // captured alongside a per-port hit flag and substituted on the returning read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld1  <= 1'b0;
      rd_vld2  <= 1'b0;
      byp1     <= 1'b0;
      byp2     <= 1'b0;
      byp_data <= '0;
    end else begin
      rd_vld1  <= ram_read_en1;
      rd_vld2  <= ram_read_en2;
      byp1     <= ram_read_en1 && ram_write_en && (ram_addr_out_1 == ram_addr_in);
      byp2     <= ram_read_en2 && ram_write_en && (ram_addr_out_2 == ram_addr_in);
      byp_data <= ram_data_in;
    end
  end

  always_comb begin
    rd_data1 = rd_hold1;
    rd_data2 = rd_hold2;
    if (rd_vld1) rd_data1 = byp1 ? byp_data : ram_data_out1;
    if (rd_vld2) rd_data2 = byp2 ? byp_data : ram_data_out2;
  end

  // Read data is combinational from the RAM output; the hold registers keep it stable between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_hold1 <= '0;
      rd_hold2 <= '0;
    end else begin
      rd_hold1 <= rd_data1;
      rd_hold2 <= rd_data2;
    end
  end

endmodule
